instr_fetch_unit: RTL and testbench

Instruction fetch front end for the RISC-V single-cycle CPU. It produces the instruction stream that the control unit decodes. It owns the PC and fetches words from instruction memory over a req/ack handshake. It presents each instruction on a valid/ready interface, with `opcode` broken out for the control unit. It applies sequential, branch, or flush redirects when an instruction is consumed.

---
 rtl/instr_fetch_unit_if.sv | 38 +++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, the valid/ready
// instruction port toward decode, and the redirect/fault signals.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;

  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, opcode, pc,
    input  instr_ready,
    input  branch_taken, branch_target, flush, flush_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, opcode, pc,
    output instr_ready,
    output branch_taken, branch_target, flush, flush_pc,
    input  fetch_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over req/ack, holds one instruction.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets in a sticky FAULT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [2:0]  state_q,    state_d;
  logic [31:0] next_pc_q,  next_pc_d;
  logic [31:0] drain_pc_q, drain_pc_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] tgt;
  logic        tgt_bad;

  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  always_comb begin
    state_d    = state_q;
    next_pc_d  = next_pc_q;
    drain_pc_d = drain_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    // Flush outranks the branch, so its target is the one checked and taken.
    tgt        = bus.flush ? bus.flush_pc : bus.branch_target;
    tgt_bad    = TRAP_EN && misaligned(tgt);

    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d   = tgt_bad ? FAULT : FETCH;
          next_pc_d = align_word(tgt);
        end else begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (bus.flush) begin
          if (tgt_bad) begin
            state_d = FAULT;
          end else if (bus.imem_ack) begin
            next_pc_d = align_word(tgt);
            state_d   = FETCH;
          end else begin
            // Request must stay stable until acked; park the target meanwhile.
            drain_pc_d = align_word(tgt);
            state_d    = DRAIN;
          end
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          pc_d    = next_pc_q;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (bus.flush || (bus.instr_ready && bus.branch_taken)) begin
          state_d   = tgt_bad ? FAULT : FETCH;
          next_pc_d = align_word(tgt);
        end else if (bus.instr_ready) begin
          next_pc_d = pc_q + 32'd4;
          state_d   = FETCH;
        end
      end

      DRAIN: begin
        if (bus.flush && tgt_bad) begin
          state_d = FAULT;
        end else begin
          if (bus.flush) drain_pc_d = align_word(tgt);
          if (bus.imem_ack) begin
            next_pc_d = bus.flush ? align_word(tgt) : drain_pc_q;
            state_d   = FETCH;
          end
        end
      end

      FAULT: state_d = FAULT;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      next_pc_q  <= RESET_PC;
      drain_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
    end else begin
      state_q    <= state_d;
      next_pc_q  <= next_pc_d;
      drain_pc_q <= drain_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  // Request and valid decode straight from state so reset drops them asynchronously.
  assign bus.imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.imem_addr   = next_pc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[6:0];
  assign bus.pc          = pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.fetch_fault = (state_q == FAULT);
`else
  assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a programmable-latency instruction memory.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared = 0;
  int fails    = 0;

  // Memory word is tagged with its address so pc/instr pairing is checkable.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[19:0], 12'h033};
  endfunction

  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;
  int unsigned consumes  = 0;

  assign bus.imem_ack   = bus.imem_req && (wait_cnt == ack_delay);
  assign bus.imem_rdata = word_at(bus.imem_addr);

  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
    if (bus.instr_valid && bus.instr_ready) consumes <= consumes + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.flush         = 1'b0;
    bus.flush_pc      = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    compared++;
    if (bus.instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL wait_valid: instr_valid=%0b after %0d cycles, want 1", bus.instr_valid, budget);
    end
  endtask

  task automatic test_reset();
    ack_delay = 0;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    compared++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %0b want 0", bus.imem_req); end
    compared++; if (bus.imem_addr !== 32'h100) begin fails++; $display("FAIL rst_addr: got %h want 00000100", bus.imem_addr); end
    compared++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", bus.instr_valid); end
    compared++; if (bus.instr !== 32'h13) begin fails++; $display("FAIL rst_instr: got %h want 00000013", bus.instr); end
    compared++; if (bus.opcode !== 7'h13) begin fails++; $display("FAIL rst_opcode: got %h want 13", bus.opcode); end
    compared++; if (bus.pc !== 32'h100) begin fails++; $display("FAIL rst_pc: got %h want 00000100", bus.pc); end
    compared++; if (bus.fetch_fault !== 1'b0) begin fails++; $display("FAIL rst_fault: got %0b want 0", bus.fetch_fault); end
    rst = 1'b0;
    compared++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL idle_req: got %0b want 0", bus.imem_req); end
    tick();
    compared++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL first_req: got %0b want 1", bus.imem_req); end
    compared++; if (bus.imem_addr !== 32'h100) begin fails++; $display("FAIL first_addr: got %h want 00000100", bus.imem_addr); end
    tick();
    compared++; if (bus.instr_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %0b want 1", bus.instr_valid); end
    compared++; if (bus.opcode !== 7'h33) begin fails++; $display("FAIL first_opcode: got %h want 33", bus.opcode); end
    compared++; if (bus.pc !== 32'h100) begin fails++; $display("FAIL first_pc: got %h want 00000100", bus.pc); end
    compared++; if (bus.instr !== 32'h0010_0033) begin fails++; $display("FAIL first_instr: got %h want 00100033", bus.instr); end
    compared++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL hold_req: got %0b want 0", bus.imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    ack_delay = 0;
    do_reset();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_addr = 32'h100 + 32'(4 * (i / 2));
      compared++;
      if (bus.imem_req !== ((i % 2) == 0)) begin
        fails++; $display("FAIL seq_req[%0d]: got %0b want %0b", i, bus.imem_req, (i % 2) == 0);
      end
      if ((i % 2) == 0) begin
        compared++;
        if (bus.imem_addr !== exp_addr) begin
          fails++; $display("FAIL seq_addr[%0d]: got %h want %h", i, bus.imem_addr, exp_addr);
        end
      end else begin
        compared++;
        if (bus.pc !== exp_addr || bus.instr !== word_at(exp_addr)) begin
          fails++; $display("FAIL seq_pc[%0d]: got pc %h instr %h want pc %h instr %h", i, bus.pc, bus.instr, exp_addr, word_at(exp_addr));
        end
      end
    end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_wait_stall();
    int unsigned c0;
    ack_delay = 3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.instr_valid !== 1'b0) begin
        fails++; $display("FAIL wait_req[%0d]: got req %0b addr %h valid %0b want 1 00000100 0", i, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
    end
    c0 = consumes;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h100 || bus.instr !== word_at(32'h100) || bus.imem_addr !== 32'h100) begin
        fails++; $display("FAIL stall_hold[%0d]: got valid %0b pc %h instr %h addr %h", i, bus.instr_valid, bus.pc, bus.instr, bus.imem_addr);
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    compared++;
    if (consumes - c0 !== 1) begin fails++; $display("FAIL stall_consume: got %0d consumes want 1", consumes - c0); end
    compared++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104 || bus.instr_valid !== 1'b0) begin
      fails++; $display("FAIL stall_next: got req %0b addr %h valid %0b want 1 00000104 0", bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    for (int i = 0; i < 6; i++) tick();
    compared++;
    if (consumes - c0 !== 1 || bus.instr_valid !== 1'b1 || bus.pc !== 32'h104) begin
      fails++; $display("FAIL stall_after: got consumes %0d valid %0b pc %h want 1 1 00000104", consumes - c0, bus.instr_valid, bus.pc);
    end
  endtask

  task automatic test_branch();
    ack_delay = 0;
    do_reset();
    tick();
    tick();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h200;
    tick();
    compared++;
    if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h100) begin
      fails++; $display("FAIL br_noconsume: got valid %0b pc %h want 1 00000100", bus.instr_valid, bus.pc);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    compared++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      fails++; $display("FAIL br_taken_addr: got req %0b addr %h want 1 00000200", bus.imem_req, bus.imem_addr);
    end
    tick();
    compared++;
    if (bus.pc !== 32'h200 || bus.instr !== word_at(32'h200)) begin
      fails++; $display("FAIL br_taken_pc: got pc %h instr %h want 00000200 %h", bus.pc, bus.instr, word_at(32'h200));
    end
    bus.branch_target = 32'h300;
    bus.instr_ready   = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    compared++;
    if (bus.imem_addr !== 32'h204) begin fails++; $display("FAIL br_not_taken: got %h want 00000204", bus.imem_addr); end
  endtask

  task automatic test_flush();
    ack_delay = 2;
    do_reset();
    wait_valid(20);
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h108;
    tick();
    clear_inputs();
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h400;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108 || bus.instr_valid !== 1'b0) begin
        fails++; $display("FAIL drain[%0d]: got req %0b addr %h valid %0b want 1 00000108 0", i, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      tick();
    end
    compared++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400 || bus.instr_valid !== 1'b0) begin
      fails++; $display("FAIL flush_refetch: got req %0b addr %h valid %0b want 1 00000400 0", bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    wait_valid(20);
    compared++;
    if (bus.pc !== 32'h400 || bus.instr !== word_at(32'h400)) begin
      fails++; $display("FAIL flush_pc: got pc %h instr %h want 00000400 %h", bus.pc, bus.instr, word_at(32'h400));
    end
    // Consume, branch and flush together: flush target must win.
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h200;
    bus.flush         = 1'b1;
    bus.flush_pc      = 32'h500;
    tick();
    clear_inputs();
    compared++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h500 || bus.instr_valid !== 1'b0) begin
      fails++; $display("FAIL flush_vs_branch: got req %0b addr %h valid %0b want 1 00000500 0", bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    ack_delay    = 0;
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h600;
    tick();
    bus.flush = 1'b0;
    compared++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h600 || bus.instr_valid !== 1'b0) begin
      fails++; $display("FAIL flush_with_ack: got req %0b addr %h valid %0b want 1 00000600 0", bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    tick();
    compared++;
    if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h600) begin
      fails++; $display("FAIL flush_with_ack_pc: got valid %0b pc %h want 1 00000600", bus.instr_valid, bus.pc);
    end
  endtask

  task automatic test_wrap();
    ack_delay = 0;
    do_reset();
    tick();
    tick();
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    tick();
    compared++;
    if (bus.pc !== 32'hFFFF_FFFC || bus.instr !== word_at(32'hFFFF_FFFC)) begin
      fails++; $display("FAIL wrap_pc: got pc %h instr %h want fffffffc %h", bus.pc, bus.instr, word_at(32'hFFFF_FFFC));
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    compared++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      fails++; $display("FAIL wrap_addr: got req %0b addr %h want 1 00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_misalign();
    ack_delay = 0;
    do_reset();
    tick();
    tick();
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h202;
    tick();
    clear_inputs();
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
        fails++; $display("FAIL fault_sticky[%0d]: got fault %0b req %0b valid %0b want 1 0 0", i, bus.fetch_fault, bus.imem_req, bus.instr_valid);
      end
      bus.flush    = 1'b1;
      bus.flush_pc = 32'h300;
      tick();
      bus.flush = 1'b0;
    end
    do_reset();
    compared++;
    if (bus.fetch_fault !== 1'b0) begin fails++; $display("FAIL fault_reset: got %0b want 0", bus.fetch_fault); end
`else
    compared++;
    if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      fails++; $display("FAIL misalign_forced: got fault %0b req %0b addr %h want 0 1 00000200", bus.fetch_fault, bus.imem_req, bus.imem_addr);
    end
    tick();
    compared++;
    if (bus.pc !== 32'h200 || bus.instr_valid !== 1'b1) begin
      fails++; $display("FAIL misalign_pc: got pc %h valid %0b want 00000200 1", bus.pc, bus.instr_valid);
    end
`endif
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sequential();
    test_wait_stall();
    test_branch();
    test_flush();
    test_wrap();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule
